// File: rtl/rename_dispatch.sv
// rename_dispatch: 4-wide register rename (RAT + circular free list) with a registered rob insert group.
// Optional macro RD_STALL_CNT_EN adds a saturating stall_cycles_o counter.
module rename_dispatch #(
    parameter int  NUM_ARCH = 32,
    parameter int  NUM_PHYS = 256,
    parameter int  OPC_W    = 11,
    localparam int ARCH_W   = $clog2(NUM_ARCH),
    localparam int PHYS_W   = $clog2(NUM_PHYS),
    localparam int CNT_W    = PHYS_W + 1
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic [3:0]        dec_valid_i,
    input  logic [ARCH_W-1:0] dec_arch_reg0_i,
    input  logic [ARCH_W-1:0] dec_arch_reg1_i,
    input  logic [ARCH_W-1:0] dec_arch_reg2_i,
    input  logic [ARCH_W-1:0] dec_arch_reg3_i,
    input  logic [OPC_W-1:0]  dec_opcode0_i,
    input  logic [OPC_W-1:0]  dec_opcode1_i,
    input  logic [OPC_W-1:0]  dec_opcode2_i,
    input  logic [OPC_W-1:0]  dec_opcode3_i,
    output logic              dec_ready_o,
    input  logic [3:0]        free_valid_i,
    input  logic [PHYS_W-1:0] free_phys_reg0_i,
    input  logic [PHYS_W-1:0] free_phys_reg1_i,
    input  logic [PHYS_W-1:0] free_phys_reg2_i,
    input  logic [PHYS_W-1:0] free_phys_reg3_i,
    input  logic              rob_full_i,
    output logic [3:0]        inserted_o,
    output logic [ARCH_W-1:0] arch_reg0_o,
    output logic [ARCH_W-1:0] arch_reg1_o,
    output logic [ARCH_W-1:0] arch_reg2_o,
    output logic [ARCH_W-1:0] arch_reg3_o,
    output logic [PHYS_W-1:0] phys_reg0_o,
    output logic [PHYS_W-1:0] phys_reg1_o,
    output logic [PHYS_W-1:0] phys_reg2_o,
    output logic [PHYS_W-1:0] phys_reg3_o,
    output logic [OPC_W-1:0]  opcode0_o,
    output logic [OPC_W-1:0]  opcode1_o,
    output logic [OPC_W-1:0]  opcode2_o,
    output logic [OPC_W-1:0]  opcode3_o,
    output logic [PHYS_W-1:0] old_phys_reg0_o,
    output logic [PHYS_W-1:0] old_phys_reg1_o,
    output logic [PHYS_W-1:0] old_phys_reg2_o,
    output logic [PHYS_W-1:0] old_phys_reg3_o,
    output logic [CNT_W-1:0]  free_count_o,
    output logic [1:0]        err_o
`ifdef RD_STALL_CNT_EN
    ,
    output logic [31:0]       stall_cycles_o
`endif
);
    localparam int FREE_DEPTH = NUM_PHYS - NUM_ARCH;
    localparam int PTR_W      = $clog2(FREE_DEPTH);

    logic [ARCH_W-1:0] dec_arch [4];
    logic [OPC_W-1:0]  dec_opc  [4];
    logic [PHYS_W-1:0] rel_phys [4];

    assign dec_arch = '{dec_arch_reg0_i, dec_arch_reg1_i, dec_arch_reg2_i, dec_arch_reg3_i};
    assign dec_opc  = '{dec_opcode0_i, dec_opcode1_i, dec_opcode2_i, dec_opcode3_i};
    assign rel_phys = '{free_phys_reg0_i, free_phys_reg1_i, free_phys_reg2_i, free_phys_reg3_i};

    logic [PHYS_W-1:0] rat_q [NUM_ARCH];
    logic [PHYS_W-1:0] rat_d [NUM_ARCH];
    logic [PHYS_W-1:0] free_list_q [FREE_DEPTH];
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]  free_count_q, free_count_d;
    logic [1:0]        err_q, err_d;

    logic [3:0]        inserted_q;
    logic [ARCH_W-1:0] arch_q [4];
    logic [PHYS_W-1:0] phys_q [4];
    logic [OPC_W-1:0]  opc_q  [4];
    logic [PHYS_W-1:0] old_q  [4];

    logic [2:0]        n_dec, n_rel, pop_cnt, push_cnt;
    logic              contig, fire, overflow;
    logic [CNT_W:0]    level_after;
    logic [PHYS_W-1:0] alloc    [4];
    logic [PHYS_W-1:0] old_phys [4];
    logic [PTR_W-1:0]  wr_idx   [4];

    function automatic logic [PTR_W-1:0] ptr_add(input logic [PTR_W-1:0] p, input logic [2:0] inc);
        logic [PTR_W:0] s;
        s = {1'b0, p} + {{(PTR_W-2){1'b0}}, inc};
        if (s >= (PTR_W+1)'(FREE_DEPTH)) s = s - (PTR_W+1)'(FREE_DEPTH);
        return s[PTR_W-1:0];
    endfunction

    always_comb begin
        n_dec = '0;
        n_rel = '0;
        for (int k = 0; k < 4; k++) begin
            // releases are compacted: each valid slot lands after those in lower slots
            wr_idx[k] = ptr_add(wr_ptr_q, n_rel);
            n_dec     = n_dec + {2'b00, dec_valid_i[k]};
            n_rel     = n_rel + {2'b00, free_valid_i[k]};
        end

        contig      = dec_valid_i inside {4'b0000, 4'b0001, 4'b0011, 4'b0111, 4'b1111};
        dec_ready_o = ~reset_i & ~rob_full_i & contig & (CNT_W'(n_dec) <= free_count_q);
        fire        = dec_ready_o & (n_dec != 3'd0);
        pop_cnt     = fire ? n_dec : 3'd0;
        level_after = {1'b0, free_count_q} - (CNT_W+1)'(pop_cnt) + (CNT_W+1)'(n_rel);
        overflow    = level_after > (CNT_W+1)'(FREE_DEPTH);
        push_cnt    = overflow ? 3'd0 : n_rel;

        for (int k = 0; k < 4; k++) begin
            alloc[k] = free_list_q[ptr_add(rd_ptr_q, 3'(k))];
        end
        // an earlier slot writing the same arch reg supersedes the RAT entry
        for (int k = 0; k < 4; k++) begin
            old_phys[k] = rat_q[dec_arch[k]];
            for (int i = 0; i < 4; i++) begin
                if (i < k && dec_valid_i[i] && dec_arch[i] == dec_arch[k]) old_phys[k] = alloc[i];
            end
        end

        rat_d = rat_q;
        if (fire) begin
            for (int k = 0; k < 4; k++) begin
                if (dec_valid_i[k]) rat_d[dec_arch[k]] = alloc[k];
            end
        end

        rd_ptr_d     = ptr_add(rd_ptr_q, pop_cnt);
        wr_ptr_d     = ptr_add(wr_ptr_q, push_cnt);
        free_count_d = free_count_q - CNT_W'(pop_cnt) + CNT_W'(push_cnt);
        err_d        = err_q | {overflow, ~contig};
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            for (int i = 0; i < NUM_ARCH; i++) rat_q[i] <= PHYS_W'(i);
            for (int i = 0; i < FREE_DEPTH; i++) free_list_q[i] <= PHYS_W'(NUM_ARCH + i);
            rd_ptr_q     <= '0;
            wr_ptr_q     <= '0;
            free_count_q <= CNT_W'(FREE_DEPTH);
            err_q        <= '0;
            inserted_q   <= '0;
            for (int k = 0; k < 4; k++) begin
                arch_q[k] <= '0;
                phys_q[k] <= '0;
                opc_q[k]  <= '0;
                old_q[k]  <= '0;
            end
        end else begin
            rat_q <= rat_d;
            if (!overflow) begin
                for (int k = 0; k < 4; k++) begin
                    if (free_valid_i[k]) free_list_q[wr_idx[k]] <= rel_phys[k];
                end
            end
            rd_ptr_q     <= rd_ptr_d;
            wr_ptr_q     <= wr_ptr_d;
            free_count_q <= free_count_d;
            err_q        <= err_d;
            if (!rob_full_i) begin
                inserted_q <= fire ? dec_valid_i : 4'b0000;
                if (fire) begin
                    for (int k = 0; k < 4; k++) begin
                        arch_q[k] <= dec_arch[k];
                        phys_q[k] <= alloc[k];
                        opc_q[k]  <= dec_opc[k];
                        old_q[k]  <= old_phys[k];
                    end
                end
            end
        end
    end

`ifdef RD_STALL_CNT_EN
    logic [31:0] stall_q;
    always_ff @(posedge clk_i) begin
        if (reset_i) stall_q <= '0;
        else if (dec_valid_i != 4'b0000 && !dec_ready_o && stall_q != 32'hFFFF_FFFF) stall_q <= stall_q + 32'd1;
    end
    assign stall_cycles_o = stall_q;
`endif

    assign inserted_o      = inserted_q;
    assign arch_reg0_o     = arch_q[0];
    assign arch_reg1_o     = arch_q[1];
    assign arch_reg2_o     = arch_q[2];
    assign arch_reg3_o     = arch_q[3];
    assign phys_reg0_o     = phys_q[0];
    assign phys_reg1_o     = phys_q[1];
    assign phys_reg2_o     = phys_q[2];
    assign phys_reg3_o     = phys_q[3];
    assign opcode0_o       = opc_q[0];
    assign opcode1_o       = opc_q[1];
    assign opcode2_o       = opc_q[2];
    assign opcode3_o       = opc_q[3];
    assign old_phys_reg0_o = old_q[0];
    assign old_phys_reg1_o = old_q[1];
    assign old_phys_reg2_o = old_q[2];
    assign old_phys_reg3_o = old_q[3];
    assign free_count_o    = free_count_q;
    assign err_o           = err_q;
endmodule

// File: tb/tb_rename_dispatch.sv
// tb_rename_dispatch: directed + random stimulus against a queue/array model of rename and dispatch.
module tb_rename_dispatch;
    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  dv, fv;
    logic [4:0]  arch [4];
    logic [10:0] opc  [4];
    logic [7:0]  fp   [4];
    logic        robf;

    logic        dec_ready;
    logic [3:0]  ins;
    logic [4:0]  o_arch [4];
    logic [7:0]  o_phys [4];
    logic [10:0] o_opc  [4];
    logic [7:0]  o_old  [4];
    logic [8:0]  fcount;
    logic [1:0]  err;
`ifdef RD_STALL_CNT_EN
    logic [31:0] stall_cycles;
`endif

    always #5 clk = ~clk;

    rename_dispatch dut (
        .clk_i(clk), .reset_i(rst), .dec_valid_i(dv),
        .dec_arch_reg0_i(arch[0]), .dec_arch_reg1_i(arch[1]),
        .dec_arch_reg2_i(arch[2]), .dec_arch_reg3_i(arch[3]),
        .dec_opcode0_i(opc[0]), .dec_opcode1_i(opc[1]),
        .dec_opcode2_i(opc[2]), .dec_opcode3_i(opc[3]),
        .dec_ready_o(dec_ready), .free_valid_i(fv),
        .free_phys_reg0_i(fp[0]), .free_phys_reg1_i(fp[1]),
        .free_phys_reg2_i(fp[2]), .free_phys_reg3_i(fp[3]),
        .rob_full_i(robf), .inserted_o(ins),
        .arch_reg0_o(o_arch[0]), .arch_reg1_o(o_arch[1]),
        .arch_reg2_o(o_arch[2]), .arch_reg3_o(o_arch[3]),
        .phys_reg0_o(o_phys[0]), .phys_reg1_o(o_phys[1]),
        .phys_reg2_o(o_phys[2]), .phys_reg3_o(o_phys[3]),
        .opcode0_o(o_opc[0]), .opcode1_o(o_opc[1]),
        .opcode2_o(o_opc[2]), .opcode3_o(o_opc[3]),
        .old_phys_reg0_o(o_old[0]), .old_phys_reg1_o(o_old[1]),
        .old_phys_reg2_o(o_old[2]), .old_phys_reg3_o(o_old[3]),
        .free_count_o(fcount), .err_o(err)
`ifdef RD_STALL_CNT_EN
        , .stall_cycles_o(stall_cycles)
`endif
    );

    // reference model: free list as a FIFO queue, RAT as a plain array
    logic [7:0]  fl [$];
    logic [7:0]  rat [32];
    logic [3:0]  e_ins;
    logic [4:0]  e_arch [4];
    logic [7:0]  e_phys [4];
    logic [10:0] e_opc  [4];
    logic [7:0]  e_old  [4];
    logic [1:0]  e_err;
    logic [31:0] e_stall;
    bit          chk_all;
    int          n_pass = 0;
    int          n_checks = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    task automatic model_reset();
        fl.delete();
        for (int i = 32; i < 256; i++) fl.push_back(8'(i));
        for (int i = 0; i < 32; i++) rat[i] = 8'(i);
        e_ins = '0;
        for (int k = 0; k < 4; k++) begin
            e_arch[k] = '0; e_phys[k] = '0; e_opc[k] = '0; e_old[k] = '0;
        end
        e_err   = '0;
        e_stall = '0;
        chk_all = 1'b1;
    endtask

    task automatic step();
        int  n;
        bit  contig, rdy, fire;
        logic [7:0] p;
        @(negedge clk);
        n      = $countones(dv);
        contig = dv inside {4'h0, 4'h1, 4'h3, 4'h7, 4'hF};
        rdy    = !rst && !robf && contig && (n <= fl.size());
        chk("dec_ready", 32'(dec_ready), 32'(rdy));
        if (rst) model_reset();
        else begin
            if (dv != 4'h0 && !rdy && e_stall != 32'hFFFF_FFFF) e_stall++;
            if (!contig) e_err[0] = 1'b1;
            fire = rdy && (n != 0);
            if (fire) begin
                for (int k = 0; k < n; k++) begin
                    p = fl.pop_front();
                    e_old[k]  = rat[arch[k]];
                    rat[arch[k]] = p;
                    e_phys[k] = p;
                    e_arch[k] = arch[k];
                    e_opc[k]  = opc[k];
                end
            end
            if (fl.size() + $countones(fv) > 224) e_err[1] = 1'b1;
            else for (int k = 0; k < 4; k++) if (fv[k]) fl.push_back(fp[k]);
            if (!robf) e_ins = fire ? dv : 4'h0;
        end
        @(posedge clk);
        #1;
        chk("inserted", 32'(ins), 32'(e_ins));
        chk("free_count", 32'(fcount), 32'(fl.size()));
        chk("err", 32'(err), 32'(e_err));
`ifdef RD_STALL_CNT_EN
        chk("stall_cycles", stall_cycles, e_stall);
`endif
        for (int k = 0; k < 4; k++) begin
            if (e_ins[k] || chk_all) begin
                chk($sformatf("arch%0d", k), 32'(o_arch[k]), 32'(e_arch[k]));
                chk($sformatf("phys%0d", k), 32'(o_phys[k]), 32'(e_phys[k]));
                chk($sformatf("opcode%0d", k), 32'(o_opc[k]), 32'(e_opc[k]));
                chk($sformatf("oldphys%0d", k), 32'(o_old[k]), 32'(e_old[k]));
            end
        end
        chk_all = 1'b0;
    endtask

    task automatic grp(input logic [3:0] v, input int a0, input int a1, input int a2, input int a3);
        dv = v;
        arch[0] = 5'(a0); arch[1] = 5'(a1); arch[2] = 5'(a2); arch[3] = 5'(a3);
        for (int k = 0; k < 4; k++) opc[k] = 11'($urandom_range(0, 2047));
    endtask

    initial begin
        int m;
        rst = 1'b1; robf = 1'b0; fv = '0; dv = '0;
        for (int k = 0; k < 4; k++) begin
            arch[k] = '0; opc[k] = '0; fp[k] = '0;
        end
        step();
        rst = 1'b0;

        // basic pair, then intra-group hazard on r5 and a later read of r5
        grp(4'b0011, 3, 7, 0, 0);   step();
        grp(4'b0111, 5, 5, 5, 0);   step();
        grp(4'b0001, 5, 0, 0, 0);   step();
        grp(4'b0000, 0, 0, 0, 0);   step();

        // rob backpressure: held group stays stable, then drains and next group follows
        grp(4'b1111, 1, 2, 3, 4);   step();
        robf = 1'b1;
        grp(4'b0011, 9, 10, 0, 0);
        for (int i = 0; i < 3; i++) step();
        robf = 1'b0;                step();
        grp(4'b0111, 11, 12, 11, 0); step();

        // drain to two free entries, then stall a 3-wide group until a release arrives
        while (fl.size() > 2) begin
            m = fl.size() - 2;
            grp((m >= 4) ? 4'b1111 : (m == 3) ? 4'b0111 : (m == 2) ? 4'b0011 : 4'b0001,
                $urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 31));
            step();
        end
        grp(4'b0111, 6, 8, 6, 0);   step();
        fv = 4'b0101; fp[0] = 8'd40; fp[1] = 8'd99; fp[2] = 8'd41; fp[3] = 8'd98;
        step();
        fv = 4'b0000;               step();
        grp(4'b0001, 6, 0, 0, 0);   step();

        // overflow and non-contiguous decode errors
        rst = 1'b1; step(); rst = 1'b0;
        grp(4'b0000, 0, 0, 0, 0);
        fv = 4'b1111; fp[0] = 8'd1; fp[1] = 8'd2; fp[2] = 8'd3; fp[3] = 8'd4;
        step();
        fv = 4'b0000;
        grp(4'b0101, 1, 2, 3, 4);   step();

        // reset while a group is held on the rob interface
        rst = 1'b1; step(); rst = 1'b0;
        grp(4'b0011, 20, 21, 0, 0); step();
        robf = 1'b1;
        grp(4'b1111, 0, 1, 2, 3);   step();
        rst = 1'b1;                 step();
        rst = 1'b0; robf = 1'b0;    step();
        grp(4'b0000, 0, 0, 0, 0);   step();

        // random traffic
        for (int c = 0; c < 400; c++) begin
            case ($urandom_range(0, 11))
                0:       dv = 4'b0000;
                1, 2:    dv = 4'b0001;
                3, 4:    dv = 4'b0011;
                5, 6:    dv = 4'b0111;
                7:       dv = 4'(($urandom_range(0, 15)));
                default: dv = 4'b1111;
            endcase
            for (int k = 0; k < 4; k++) begin
                arch[k] = 5'($urandom_range(0, 7));
                opc[k]  = 11'($urandom_range(0, 2047));
                fp[k]   = 8'($urandom_range(0, 255));
            end
            fv   = ($urandom_range(0, 2) == 0) ? 4'($urandom_range(0, 15)) : 4'b0000;
            robf = ($urandom_range(0, 4) == 0);
            rst  = ($urandom_range(0, 99) == 0);
            step();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
